// File: rtl/sb_rx_msg_decoder_q_pkg.sv
// Shared definitions for the sideband RX RDI message decoder: MsgCode classes,
// header field positions, default output widths and the decoded message record.
// No logic; imported by the interface, the decoder top and the bench.
package sb_rx_pkg;

    // Default widths of the decoded fields handed to the RDI state machine.
    localparam int MSG_CODE_W = 2;
    localparam int MSG_SUB_W  = 4;
    localparam int MSG_INFO_W = 2;

    // MsgCode classes; anything above MSG_RESP is illegal.
    localparam logic [7:0] MSG_NOP  = 8'd0;
    localparam logic [7:0] MSG_REQ  = 8'd1;
    localparam logic [7:0] MSG_RESP = 8'd2;

    // Header field layout (64-bit sideband message header).
    localparam int HDR_W        = 64;
    localparam int HDR_CODE_LSB = 14;
    localparam int HDR_CODE_W   = 8;
    localparam int HDR_SUB_LSB  = 32;
    localparam int HDR_SUB_W    = 8;
    localparam int HDR_INFO_LSB = 40;
    localparam int HDR_INFO_W   = 16;
    localparam int HDR_CP_BIT   = 63;

    typedef struct packed {
        logic [MSG_CODE_W-1:0] code;
        logic [MSG_SUB_W-1:0]  sub_code;
        logic [MSG_INFO_W-1:0] info;
    } rdi_msg_t;

    function automatic logic code_legal(input logic [HDR_CODE_W-1:0] code);
        return code <= MSG_RESP;
    endfunction

endpackage

// File: rtl/sb_rx_msg_decoder_q_if.sv
// Bus bundle between the header router, the decoder queue and the RDI consumer.
// slave: decoder side (takes header + ready, drives head/status); master: the
// surrounding logic. o_level is $clog2(DEPTH)+1 bits so it can hold DEPTH.
interface sb_rx_msg_decoder_q_if
    import sb_rx_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int CODE_W     = MSG_CODE_W,
    parameter int SUB_W      = MSG_SUB_W,
    parameter int INFO_W     = MSG_INFO_W,
    parameter int DROP_CNT_W = 8
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic                  i_hdr_valid;
    logic [HDR_W-1:0]      i_header;
    logic                  o_msg_valid;
    logic                  i_msg_ready;
    logic [CODE_W-1:0]     o_msg_code;
    logic [SUB_W-1:0]      o_msg_sub_code;
    logic [INFO_W-1:0]     o_msg_info;
    logic                  o_err_pulse;
    logic                  o_overflow;
    logic [DROP_CNT_W-1:0] o_drop_cnt;
    logic [LVL_W-1:0]      o_level;

    modport slave (
        input  i_hdr_valid, i_header, i_msg_ready,
        output o_msg_valid, o_msg_code, o_msg_sub_code, o_msg_info,
        output o_err_pulse, o_overflow, o_drop_cnt, o_level
    );

    modport master (
        output i_hdr_valid, i_header, i_msg_ready,
        input  o_msg_valid, o_msg_code, o_msg_sub_code, o_msg_info,
        input  o_err_pulse, o_overflow, o_drop_cnt, o_level
    );

endinterface

// File: rtl/sb_rx_msg_fifo.sv
// Generic synchronous FIFO (DEPTH entries, power of two, W-bit payload).
// Latency: push visible at pop_dat one cycle later; head is read from storage flops.
// Backpressure: push accepted when not full, or when full with a pop in the same cycle.
module sb_rx_msg_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     core_clk,
    input  logic                     arst_n,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level_q;
    logic             pop_ok;
    logic             push_ok;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign pop_ok  = pop && !empty;
    // A full FIFO frees its head slot this cycle when popping, so the write lands.
    assign push_ok = push && (!full || pop_ok);

    assign pop_dat = mem[rd_ptr];
    assign level   = level_q;

    // Pointers are PTR_W bits, so DEPTH being a power of two gives free wrap.
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/sb_rx_msg_decoder_q.sv
// Sideband RX RDI message decoder: checks MsgCode (and CP when SB_RX_PARITY_CHECK_EN
// is defined), decodes code/sub/info and queues them. Latency: header to head in 1 cycle.
// Backpressure: valid/ready pop; legal headers arriving to a full queue are dropped.
//
// Ports: i_clk, i_rst_n (async active-low); bus (slave modport) carries i_hdr_valid,
// i_header, i_msg_ready in and o_msg_valid, o_msg_code/sub_code/info, o_err_pulse,
// o_overflow (sticky), o_drop_cnt (saturating), o_level out.
// Optional macro SB_RX_PARITY_CHECK_EN: enables the CP check on header bit 63.
module sb_rx_msg_decoder_q
    import sb_rx_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int CODE_W     = MSG_CODE_W,
    parameter int SUB_W      = MSG_SUB_W,
    parameter int INFO_W     = MSG_INFO_W,
    parameter int DROP_CNT_W = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    sb_rx_msg_decoder_q_if.slave    bus
);
    localparam int PAY_W = CODE_W + SUB_W + INFO_W;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [HDR_CODE_W-1:0] hdr_code;
    logic [HDR_SUB_W-1:0]  hdr_sub;
    logic [HDR_INFO_W-1:0] hdr_info;
    logic                  parity_ok;
    logic                  hdr_ok;
    logic                  rejected;
    logic                  legal;
    logic                  pop;
    logic                  push;
    logic                  overflow_drop;
    logic [INFO_W-1:0]     info_dec;
    logic [PAY_W-1:0]      push_dat;
    logic [PAY_W-1:0]      head_dat;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [LVL_W-1:0]      fifo_level;
    logic                  err_q;
    logic                  ovf_q;
    logic [DROP_CNT_W-1:0] drop_q;
    logic                  unused_hdr;

    assign hdr_code = bus.i_header[HDR_CODE_LSB +: HDR_CODE_W];
    assign hdr_sub  = bus.i_header[HDR_SUB_LSB  +: HDR_SUB_W];
    assign hdr_info = bus.i_header[HDR_INFO_LSB +: HDR_INFO_W];

    // Reserved header bits (and CP when parity is off) carry no meaning here.
    assign unused_hdr = ^bus.i_header;

`ifdef SB_RX_PARITY_CHECK_EN
    assign parity_ok = ((^bus.i_header[HDR_CP_BIT-1:0]) == bus.i_header[HDR_CP_BIT]);
`else
    assign parity_ok = 1'b1;
`endif

    assign hdr_ok        = code_legal(hdr_code) && parity_ok;
    assign rejected      = bus.i_hdr_valid && !hdr_ok;
    assign legal         = bus.i_hdr_valid && hdr_ok;
    assign pop           = !fifo_empty && bus.i_msg_ready;
    assign push          = legal && (!fifo_full || pop);
    assign overflow_drop = legal && fifo_full && !pop;

    // Only Nop and Resp carry info to the RDI machine; Resp carries a single bit.
    always_comb begin
        info_dec = '0;
        case (hdr_code)
            MSG_NOP:  info_dec = INFO_W'(hdr_info);
            MSG_RESP: info_dec = INFO_W'(hdr_info[0]);
            default:  info_dec = '0;
        endcase
    end

    assign push_dat = {CODE_W'(hdr_code), SUB_W'(hdr_sub), info_dec};

    sb_rx_msg_fifo #(
        .DEPTH (DEPTH),
        .W     (PAY_W)
    ) u_fifo (
        .core_clk (i_clk),
        .arst_n   (i_rst_n),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .pop_dat  (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_q  <= 1'b0;
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            err_q <= rejected;
            if (overflow_drop) begin
                ovf_q <= 1'b1;
            end
            if ((rejected || overflow_drop) && (drop_q != '1)) begin
                drop_q <= drop_q + DROP_CNT_W'(1);
            end
        end
    end

    assign bus.o_msg_valid    = !fifo_empty;
    assign bus.o_msg_code     = head_dat[PAY_W-1 -: CODE_W];
    assign bus.o_msg_sub_code = head_dat[INFO_W +: SUB_W];
    assign bus.o_msg_info     = head_dat[INFO_W-1:0];
    assign bus.o_err_pulse    = err_q;
    assign bus.o_overflow     = ovf_q;
    assign bus.o_drop_cnt     = drop_q;
    assign bus.o_level        = fifo_level;

endmodule

// File: tb/tb_sb_rx_msg_decoder_q.sv
// Bench for sb_rx_msg_decoder_q: directed vector table, hand-written corner
// sequences (CP, overflow, saturation, async reset) and a random run against a
// queue-based reference model. Honours SB_RX_PARITY_CHECK_EN like the design.
module tb_sb_rx_msg_decoder_q;
    import sb_rx_pkg::*;

    localparam int DEPTH      = 4;
    localparam int CODE_W     = MSG_CODE_W;
    localparam int SUB_W      = MSG_SUB_W;
    localparam int INFO_W     = MSG_INFO_W;
    localparam int DROP_CNT_W = 8;
    localparam int DROP_MAX   = (1 << DROP_CNT_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sb_rx_msg_decoder_q_if #(
        .DEPTH(DEPTH), .CODE_W(CODE_W), .SUB_W(SUB_W), .INFO_W(INFO_W), .DROP_CNT_W(DROP_CNT_W)
    ) bus ();

    sb_rx_msg_decoder_q #(
        .DEPTH(DEPTH), .CODE_W(CODE_W), .SUB_W(SUB_W), .INFO_W(INFO_W), .DROP_CNT_W(DROP_CNT_W)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        bit hv;   int code; int sub;  int info; bit rdy;
        bit ev;   int ecode; int esub; int einfo; int elvl; bit eerr; int edrop;
    } vec_t;

    // Reference model state: the queue contents as decoded records.
    rdi_msg_t mq[$];
    bit       m_ovf;
    bit       m_err;
    int       m_drop;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Random filler everywhere, then the fields, then CP (optionally corrupted).
    function automatic logic [63:0] mk(input int code, input int sub, input int info, input bit bad);
        logic [63:0] h;
        logic [31:0] c;
        logic [31:0] s;
        logic [31:0] f;
        c = code; s = sub; f = info;
        h = {$urandom, $urandom};
        h[21:14] = c[7:0];
        h[39:32] = s[7:0];
        h[55:40] = f[15:0];
        h[63]    = (^h[62:0]) ^ bad;
        return h;
    endfunction

    function automatic rdi_msg_t decode(input int code, input int sub, input int info);
        rdi_msg_t m;
        m.code     = MSG_CODE_W'(code);
        m.sub_code = MSG_SUB_W'(sub);
        if (code == 0)      m.info = MSG_INFO_W'(info);
        else if (code == 2) m.info = MSG_INFO_W'(info % 2);
        else                m.info = '0;
        return m;
    endfunction

    task automatic drive(input bit hv, input logic [63:0] h, input bit rdy);
        @(negedge clk);
        bus.i_hdr_valid = hv;
        bus.i_header    = h;
        bus.i_msg_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n           = 1'b0;
        bus.i_hdr_valid = 1'b0;
        bus.i_header    = '0;
        bus.i_msg_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        m_ovf  = 1'b0;
        m_err  = 1'b0;
        m_drop = 0;
    endtask

    // One clock of the model, from the pre-edge queue and the applied inputs.
    task automatic model_step(input bit hv, input logic [63:0] h, input bit rdy);
        int code;
        int sub;
        int info;
        bit par_ok;
        bit pop;
        bit push;
        code = int'(h[21:14]);
        sub  = int'(h[39:32]);
        info = int'(h[55:40]);
`ifdef SB_RX_PARITY_CHECK_EN
        par_ok = ((^h) == 1'b0);
`else
        par_ok = 1'b1;
`endif
        pop   = (mq.size() > 0) && rdy;
        push  = 1'b0;
        m_err = 1'b0;
        if (hv && (code > 2 || !par_ok)) begin
            m_err = 1'b1;
            if (m_drop < DROP_MAX) m_drop++;
        end else if (hv) begin
            if (mq.size() < DEPTH || pop) begin
                push = 1'b1;
            end else begin
                m_ovf = 1'b1;
                if (m_drop < DROP_MAX) m_drop++;
            end
        end
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back(decode(code, sub, info));
    endtask

    task automatic compare_model(input int cyc);
        check($sformatf("rnd%0d valid", cyc), 64'(bus.o_msg_valid), 64'(mq.size() != 0));
        check($sformatf("rnd%0d level", cyc), 64'(bus.o_level), 64'(mq.size()));
        if (mq.size() != 0) begin
            check($sformatf("rnd%0d head", cyc),
                  64'({bus.o_msg_code, bus.o_msg_sub_code, bus.o_msg_info}), 64'(mq[0]));
        end
        check($sformatf("rnd%0d err", cyc),  64'(bus.o_err_pulse), 64'(m_err));
        check($sformatf("rnd%0d ovf", cyc),  64'(bus.o_overflow),  64'(m_ovf));
        check($sformatf("rnd%0d drop", cyc), 64'(bus.o_drop_cnt),  64'(m_drop));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " valid"}, 64'(bus.o_msg_valid),    64'(0));
        check({tag, " code"},  64'(bus.o_msg_code),     64'(0));
        check({tag, " sub"},   64'(bus.o_msg_sub_code), 64'(0));
        check({tag, " info"},  64'(bus.o_msg_info),     64'(0));
        check({tag, " err"},   64'(bus.o_err_pulse),    64'(0));
        check({tag, " ovf"},   64'(bus.o_overflow),     64'(0));
        check({tag, " drop"},  64'(bus.o_drop_cnt),     64'(0));
        check({tag, " level"}, 64'(bus.o_level),        64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[13];
        bit   hv;
        bit   rdy;
        bit   bad;
        int   code;
        logic [63:0] h;

        bus.i_hdr_valid = 1'b0;
        bus.i_header    = '0;
        bus.i_msg_ready = 1'b0;
        #12;
        check_all_zero("reset");

        // ---------------- directed table ----------------
        //            hv code sub    info     rdy  ev ec es  ei lvl err drop
        tbl[0]  = '{1, 1,    3,     'hABCD,  1,   1, 1, 3,  0, 1,  0,  0};
        tbl[1]  = '{0, 0,    0,     0,       1,   0, 0, 0,  0, 0,  0,  0};
        tbl[2]  = '{1, 0,    'h15,  'h0002,  0,   1, 0, 5,  2, 1,  0,  0};
        tbl[3]  = '{1, 2,    'h2A,  'hFFFF,  0,   1, 0, 5,  2, 2,  0,  0};
        tbl[4]  = '{0, 0,    0,     0,       1,   1, 2, 10, 1, 1,  0,  0};
        tbl[5]  = '{0, 0,    0,     0,       1,   0, 0, 0,  0, 0,  0,  0};
        tbl[6]  = '{1, 5,    0,     0,       0,   0, 0, 0,  0, 0,  1,  1};
        tbl[7]  = '{0, 0,    0,     0,       0,   0, 0, 0,  0, 0,  0,  1};
        tbl[8]  = '{1, 3,    0,     0,       0,   0, 0, 0,  0, 0,  1,  2};
        tbl[9]  = '{1, 'h82, 0,     0,       0,   0, 0, 0,  0, 0,  1,  3};
        tbl[10] = '{1, 2,    'hF3,  'h0000,  0,   1, 2, 3,  0, 1,  0,  3};
        tbl[11] = '{1, 0,    0,     'hFFFF,  1,   1, 0, 0,  3, 1,  0,  3};
        tbl[12] = '{0, 0,    0,     0,       1,   0, 0, 0,  0, 0,  0,  3};

        do_reset();
        for (int k = 0; k < 13; k++) begin
            drive(tbl[k].hv, mk(tbl[k].code, tbl[k].sub, tbl[k].info, 1'b0), tbl[k].rdy);
            check($sformatf("vec%0d valid", k), 64'(bus.o_msg_valid), 64'(tbl[k].ev));
            check($sformatf("vec%0d level", k), 64'(bus.o_level),     64'(tbl[k].elvl));
            check($sformatf("vec%0d err", k),   64'(bus.o_err_pulse), 64'(tbl[k].eerr));
            check($sformatf("vec%0d drop", k),  64'(bus.o_drop_cnt),  64'(tbl[k].edrop));
            check($sformatf("vec%0d ovf", k),   64'(bus.o_overflow),  64'(0));
            if (tbl[k].ev) begin
                check($sformatf("vec%0d code", k), 64'(bus.o_msg_code),     64'(tbl[k].ecode));
                check($sformatf("vec%0d sub", k),  64'(bus.o_msg_sub_code), 64'(tbl[k].esub));
                check($sformatf("vec%0d info", k), 64'(bus.o_msg_info),     64'(tbl[k].einfo));
            end
        end

        // ---------------- corrupted CP ----------------
        do_reset();
        drive(1'b1, mk(1, 7, 0, 1'b1), 1'b0);
`ifdef SB_RX_PARITY_CHECK_EN
        check("cp err",   64'(bus.o_err_pulse), 64'(1));
        check("cp drop",  64'(bus.o_drop_cnt),  64'(1));
        check("cp level", 64'(bus.o_level),     64'(0));
`else
        check("cp err",   64'(bus.o_err_pulse),    64'(0));
        check("cp level", 64'(bus.o_level),        64'(1));
        check("cp sub",   64'(bus.o_msg_sub_code), 64'(7));
`endif

        // ---------------- overflow ----------------
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, mk(1, i + 1, 0, 1'b0), 1'b0);
        end
        check("ovf level", 64'(bus.o_level),        64'(4));
        check("ovf flag",  64'(bus.o_overflow),     64'(1));
        check("ovf drop",  64'(bus.o_drop_cnt),     64'(1));
        check("ovf err",   64'(bus.o_err_pulse),    64'(0));
        check("ovf head",  64'(bus.o_msg_sub_code), 64'(1));
        drive(1'b1, mk(1, 6, 0, 1'b0), 1'b1);
        check("fullpop level", 64'(bus.o_level),        64'(4));
        check("fullpop head",  64'(bus.o_msg_sub_code), 64'(2));
        check("fullpop drop",  64'(bus.o_drop_cnt),     64'(1));
        drive(1'b0, '0, 1'b1);
        check("drain1 head", 64'(bus.o_msg_sub_code), 64'(3));
        drive(1'b0, '0, 1'b1);
        check("drain2 head", 64'(bus.o_msg_sub_code), 64'(4));
        drive(1'b0, '0, 1'b1);
        check("drain3 head", 64'(bus.o_msg_sub_code), 64'(6));
        drive(1'b0, '0, 1'b1);
        check("drain4 valid", 64'(bus.o_msg_valid), 64'(0));
        check("drain4 ovf",   64'(bus.o_overflow),  64'(1));

        // ---------------- drop counter saturation ----------------
        do_reset();
        for (int i = 0; i < 260; i++) begin
            drive(1'b1, mk(3 + (i % 253), i, i, 1'b0), 1'b0);
            if (i == 253) check("sat pre", 64'(bus.o_drop_cnt), 64'(254));
        end
        check("sat drop", 64'(bus.o_drop_cnt), 64'(DROP_MAX));
        check("sat err",  64'(bus.o_err_pulse), 64'(1));
        drive(1'b0, '0, 1'b0);
        check("sat hold", 64'(bus.o_drop_cnt), 64'(DROP_MAX));
        check("sat err off", 64'(bus.o_err_pulse), 64'(0));

        // ---------------- async reset mid-operation ----------------
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, mk(0, 9 + i, 3, 1'b0), 1'b0);
        end
        drive(1'b1, mk(7, 0, 0, 1'b0), 1'b0);
        check("pre-rst level", 64'(bus.o_level),     64'(3));
        check("pre-rst err",   64'(bus.o_err_pulse), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async rst");

        // ---------------- randomized vs reference model ----------------
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            hv   = ($urandom_range(0, 9) < 6);
            code = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 2)) : int'($urandom_range(3, 255));
            bad  = ($urandom_range(0, 7) == 0);
            rdy  = (c < 1500) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
            h    = mk(code, int'($urandom_range(0, 255)), int'($urandom_range(0, 65535)), bad);
            drive(hv, h, rdy);
            model_step(hv, h, rdy);
            compare_model(c);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
